apb_interconnect: RTL and testbench
===================================

Name: apb_interconnect

Overview:
- Single-master, three-slave APB-style interconnect between the `cpu` master and the `sram`, `uart` and `sys_sram` slaves.
- Decodes `paddr` and fans out select/enable to exactly one slave.
- Muxes the selected slave's read data, ready and error back to the master.
- Answers unmapped and timed-out transfers itself with an error completion.

Parameters:
- ADDR_WIDTH, 32, address bus width.
- DATA_WIDTH, 32, data bus width.
- TIMEOUT_CYCLES, 256, maximum access-phase wait states before the bus forces an error completion.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rts  in  1  reset; asynchronous, active-low.
- paddr  in  ADDR_WIDTH  master address.
- pwdata  in  DATA_WIDTH  master write data; routed to slaves externally, unused internally.
- prdata  out  DATA_WIDTH  read data to master.
- psel  in  1  master select.
- penable  in  1  master access phase.
- pwrite  in  1  write strobe; passthrough, decode-independent.
- pstb  in  4  byte strobes; unused internally.
- pready  out  1  transfer complete to master.
- perr  out  1  transfer error to master; valid only with pready.
- sram_sel/uart_sel/sys_sel  out  1 each  per-slave select.
- sram_enable/uart_enable/sys_enable  out  1 each  per-slave access phase.
- sram_rdata/uart_rdata/sys_rdata  in  DATA_WIDTH each  slave read data.
- sram_ready/uart_ready/sys_ready  in  1 each  slave ready.
- sram_err/uart_err/sys_err  in  1 each  slave error.

Behaviour:
- Address map, combinational on paddr:
  - paddr[31]=1 → SRAM; the slave sees paddr[30:0] with bit 31 zeroed externally.
  - paddr[31:12]=0x10000 → UART.
  - paddr[31:28]=0 → SYSTEM.
  - Anything else → UNMAPPED.
- x_sel = psel & hit_x. At most one sel is high at any time.
- x_enable = psel & penable & hit_x.
- Return mux, driven from the decoded slave while psel=1:
  - prdata = slave rdata; 0 when UNMAPPED or psel=0.
  - pready = slave ready & penable.
  - perr = slave err & slave ready & penable.
- UNMAPPED access phase (psel & penable): pready=1, perr=1, prdata=0 in the same cycle. This is zero wait states.
- Phase FSM, registered, three states:
  - IDLE → SETUP on psel & !penable.
  - SETUP → ACCESS on psel & penable.
  - ACCESS → IDLE when pready out is 1.
  - ACCESS → SETUP when pready=1 and the next cycle has psel & !penable (back-to-back transfer).
  - psel deasserted in any state → IDLE.
- Protocol violation: psel & penable while state=IDLE, i.e. no setup cycle.
  - The bus answers pready=1, perr=1.
  - No slave enable is asserted.
- Timeout:
  - The counter resets to 0 on entry to ACCESS and increments each ACCESS cycle with slave ready=0.
  - When the count reaches TIMEOUT_CYCLES-1: force pready=1, perr=1, prdata=0 that cycle.
  - The slave enable stays asserted that cycle; the master terminates the transfer.
- While rts=0: FSM=IDLE, counter=0, pready=0, perr=0, all sel/enable=0, prdata=0. This overrides combinational paths.
- Reset asserted mid-transfer aborts it immediately. No completion is issued.
- pwrite/pstb/pwdata never affect decode or timing.

Decomposition:
- Shared package apb_pkg holds:
  - slave index enum: SLV_NONE, SLV_SRAM, SLV_UART, SLV_SYS.
  - address map constants: SRAM_BIT=31, UART_BASE=0x1000_0000, UART_MASK=0xFFFF_F000, SYS_MASK=0xF000_0000.
  - phase enum: IDLE, SETUP, ACCESS.
- One sub-module is natural: apb_decoder, combinational paddr → slave index. The FSM, timeout and return mux stay in the top.

Test Plan:
- Read paddr=0x8000_0010, sram_rdata=0xDEADBEEF, sram_ready high in access → sram_sel in setup, sram_enable in access, prdata=0xDEADBEEF, pready=1, perr=0; uart/sys sel stay 0.
- Write paddr=0x1000_0000, uart_ready delayed 3 cycles → pready=0 for 3 access cycles, then 1; uart_enable high for all 4.
- Access paddr=0x4000_0000 → no slave sel; access cycle pready=1, perr=1, prdata=0.
- sys slave at 0x0000_0100 never ready, TIMEOUT_CYCLES=8 → pready=perr=1 on 8th access cycle, FSM back to IDLE.
- psel & penable asserted from IDLE at 0x8000_0000 → sram_enable=0, pready=1, perr=1.
- rts driven low mid-ACCESS → all outputs 0 asynchronously; after release, a new read to 0x8000_0000 completes normally.

Source files
------------

// File: rtl/apb_interconnect_pkg.sv
// Shared types and address-map constants for the APB interconnect.
package apb_pkg;

  typedef enum logic [1:0] {
    SLV_NONE,
    SLV_SRAM,
    SLV_UART,
    SLV_SYS
  } slave_e;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } phase_e;

  localparam int          SRAM_BIT  = 31;
  localparam logic [31:0] UART_BASE = 32'h1000_0000;
  localparam logic [31:0] UART_MASK = 32'hFFFF_F000;
  localparam logic [31:0] SYS_MASK  = 32'hF000_0000;

endpackage

// File: rtl/apb_interconnect_if.sv
// Master-side APB bus bundle between the cpu and the interconnect.
interface apb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [3:0]            pstb;
  logic                  pready;
  logic                  perr;

  modport master (
    output paddr, pwdata, psel, penable, pwrite, pstb,
    input  prdata, pready, perr
  );

  modport slave (
    input  paddr, pwdata, psel, penable, pwrite, pstb,
    output prdata, pready, perr
  );

endinterface

// File: rtl/apb_interconnect_decoder.sv
// Combinational address decode: paddr -> target slave.
module apb_decoder
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] paddr,
  output slave_e                slave
);

  // SRAM owns the upper half; UART is one 4 KiB page; SYSTEM is the low 256 MiB.
  always_comb begin
    slave = SLV_NONE;
    if (paddr[SRAM_BIT])
      slave = SLV_SRAM;
    else if ((paddr & ADDR_WIDTH'(UART_MASK)) == ADDR_WIDTH'(UART_BASE))
      slave = SLV_UART;
    else if ((paddr & ADDR_WIDTH'(SYS_MASK)) == '0)
      slave = SLV_SYS;
  end

endmodule

// File: rtl/apb_interconnect.sv
// Single-master, three-slave APB interconnect with unmapped, protocol
// violation and access-phase timeout error completions.
module apb_interconnect
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rts,
  apb_if.slave                  cpu,
  output logic                  sram_sel,
  output logic                  uart_sel,
  output logic                  sys_sel,
  output logic                  sram_enable,
  output logic                  uart_enable,
  output logic                  sys_enable,
  input  logic [DATA_WIDTH-1:0] sram_rdata,
  input  logic [DATA_WIDTH-1:0] uart_rdata,
  input  logic [DATA_WIDTH-1:0] sys_rdata,
  input  logic                  sram_ready,
  input  logic                  uart_ready,
  input  logic                  sys_ready,
  input  logic                  sram_err,
  input  logic                  uart_err,
  input  logic                  sys_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  slave_e                slave;
  phase_e                state;
  logic [CNT_W-1:0]      cnt;
  logic                  mapped;
  logic                  viol;
  logic                  access_phase;
  logic                  timeout;
  logic [DATA_WIDTH-1:0] s_rdata;
  logic                  s_ready;
  logic                  s_err;
  logic [DATA_WIDTH-1:0] rdata_mux;
  logic                  ready_mux;
  logic                  err_mux;
  logic                  unused_bus;

  apb_decoder #(.ADDR_WIDTH(ADDR_WIDTH)) u_decoder (
    .paddr (cpu.paddr),
    .slave (slave)
  );

  // Write data, strobes and direction are routed outside; they never steer decode.
  assign unused_bus = ^{cpu.pwdata, cpu.pstb, cpu.pwrite};

  assign mapped = (slave != SLV_NONE);
  // Access phase without a preceding setup cycle.
  assign viol = cpu.psel & cpu.penable & (state == IDLE);
  // A legal access phase to a real slave; only these cycles reach a slave enable.
  assign access_phase = cpu.psel & cpu.penable & (state != IDLE) & mapped;
  assign timeout = access_phase & (cnt == CNT_LAST);

  // Reset gating keeps every select/enable low while rts is held, even with psel high.
  assign sram_sel    = rts & cpu.psel & (slave == SLV_SRAM);
  assign uart_sel    = rts & cpu.psel & (slave == SLV_UART);
  assign sys_sel     = rts & cpu.psel & (slave == SLV_SYS);
  assign sram_enable = rts & access_phase & (slave == SLV_SRAM);
  assign uart_enable = rts & access_phase & (slave == SLV_UART);
  assign sys_enable  = rts & access_phase & (slave == SLV_SYS);

  // Pick the decoded slave's response signals.
  always_comb begin
    s_rdata = '0;
    s_ready = 1'b0;
    s_err   = 1'b0;
    case (slave)
      SLV_SRAM: begin s_rdata = sram_rdata; s_ready = sram_ready; s_err = sram_err; end
      SLV_UART: begin s_rdata = uart_rdata; s_ready = uart_ready; s_err = uart_err; end
      SLV_SYS:  begin s_rdata = sys_rdata;  s_ready = sys_ready;  s_err = sys_err;  end
      default:  ;
    endcase
  end

  // Return path: bus-generated errors take priority over the slave's answer.
  always_comb begin
    rdata_mux = '0;
    ready_mux = 1'b0;
    err_mux   = 1'b0;
    if (rts && cpu.psel) begin
      if (viol || timeout) begin
        ready_mux = 1'b1;
        err_mux   = 1'b1;
      end else if (!mapped) begin
        ready_mux = cpu.penable;
        err_mux   = cpu.penable;
      end else begin
        rdata_mux = s_rdata;
        ready_mux = s_ready & cpu.penable;
        err_mux   = s_err & s_ready & cpu.penable;
      end
    end
  end

  assign cpu.prdata = rdata_mux;
  assign cpu.pready = ready_mux;
  assign cpu.perr   = err_mux;

  // Phase tracking and wait-state counter; a completion always returns to IDLE
  // so a following setup cycle is recognised as a fresh transfer.
  always_ff @(posedge clk or negedge rts) begin
    if (!rts) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      if (access_phase && !ready_mux)
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;

      if (!cpu.psel) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE:    if (!cpu.penable) state <= SETUP;
          SETUP:   if (cpu.penable) state <= ready_mux ? IDLE : ACCESS;
          ACCESS: begin
            if (ready_mux)         state <= IDLE;
            else if (!cpu.penable) state <= SETUP;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apb_interconnect.sv
// Directed bench with a completion scoreboard for apb_interconnect.
module tb_apb_interconnect;
  import apb_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rts = 1'b0;
  logic        sram_sel, uart_sel, sys_sel;
  logic        sram_enable, uart_enable, sys_enable;
  logic [31:0] sram_rdata = '0, uart_rdata = '0, sys_rdata = '0;
  logic        sram_ready = 1'b0, uart_ready = 1'b0, sys_ready = 1'b0;
  logic        sram_err = 1'b0, uart_err = 1'b0, sys_err = 1'b0;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  apb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) cpu ();

  apb_interconnect #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rts(rts), .cpu(cpu.slave),
    .sram_sel(sram_sel), .uart_sel(uart_sel), .sys_sel(sys_sel),
    .sram_enable(sram_enable), .uart_enable(uart_enable), .sys_enable(sys_enable),
    .sram_rdata(sram_rdata), .uart_rdata(uart_rdata), .sys_rdata(sys_rdata),
    .sram_ready(sram_ready), .uart_ready(uart_ready), .sys_ready(sys_ready),
    .sram_err(sram_err), .uart_err(uart_err), .sys_err(sys_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push(input string name, input logic [31:0] rdata, input logic err);
    exp_t e;
    e.name  = name;
    e.rdata = rdata;
    e.err   = err;
    exp_q.push_back(e);
  endtask

  task automatic bus(input logic [31:0] addr, input logic sel, input logic en);
    cpu.paddr   = addr;
    cpu.psel    = sel;
    cpu.penable = en;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pready"}, {31'd0, cpu.pready}, 32'd0);
    chk({tag, "_perr"}, {31'd0, cpu.perr}, 32'd0);
    chk({tag, "_prdata"}, cpu.prdata, 32'd0);
    chk({tag, "_sels"}, {29'd0, sram_sel, uart_sel, sys_sel}, 32'd0);
    chk({tag, "_enables"}, {29'd0, sram_enable, uart_enable, sys_enable}, 32'd0);
  endtask

  // Completion monitor: every pready pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (cpu.pready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_completion prdata=%h perr=%b", cpu.prdata, cpu.perr);
      end else begin
        mon_e = exp_q.pop_front();
        chk({mon_e.name, "_prdata"}, cpu.prdata, mon_e.rdata);
        chk({mon_e.name, "_perr"}, {31'd0, cpu.perr}, {31'd0, mon_e.err});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cpu.pwdata = 32'hA5A5_A5A5;
    cpu.pwrite = 1'b0;
    cpu.pstb   = 4'hF;
    // Reset overrides the combinational paths even with a live access presented.
    bus(32'h8000_0000, 1'b1, 1'b1);
    sram_ready = 1'b1; sram_err = 1'b1; sram_rdata = 32'hFFFF_FFFF;
    smp();
    chk_all_zero("reset");
    nxt();
    bus(32'h0, 1'b0, 1'b0);
    sram_ready = 1'b0; sram_err = 1'b0;
    nxt();
    rts = 1'b1;

    // SRAM read, zero wait states.
    nxt();
    bus(32'h8000_0010, 1'b1, 1'b0);
    sram_rdata = 32'hDEAD_BEEF; sram_ready = 1'b1;
    push("sram_read", 32'hDEAD_BEEF, 1'b0);
    smp();
    chk("sram_setup_sel", {29'd0, sram_sel, uart_sel, sys_sel}, 32'd4);
    chk("sram_setup_enable", {31'd0, sram_enable}, 32'd0);
    chk("sram_setup_pready", {31'd0, cpu.pready}, 32'd0);
    nxt();
    cpu.penable = 1'b1;
    smp();
    chk("sram_access_enable", {29'd0, sram_enable, uart_enable, sys_enable}, 32'd4);
    nxt();
    bus(32'h0, 1'b0, 1'b0);
    sram_ready = 1'b0;

    // UART write with three wait states.
    nxt();
    cpu.pwrite = 1'b1;
    bus(32'h1000_0000, 1'b1, 1'b0);
    uart_rdata = 32'h0000_1234; uart_ready = 1'b0;
    push("uart_write", 32'h0000_1234, 1'b0);
    smp();
    chk("uart_setup_sel", {29'd0, sram_sel, uart_sel, sys_sel}, 32'd2);
    for (int i = 0; i < 4; i++) begin
      nxt();
      cpu.penable = 1'b1;
      uart_ready = (i == 3);
      smp();
      chk($sformatf("uart_enable_%0d", i), {31'd0, uart_enable}, 32'd1);
      if (i < 3) chk($sformatf("uart_wait_%0d", i), {31'd0, cpu.pready}, 32'd0);
    end
    nxt();
    bus(32'h0, 1'b0, 1'b0);
    uart_ready = 1'b0;
    cpu.pwrite = 1'b0;

    // Unmapped address answered by the bus itself.
    nxt();
    bus(32'h4000_0000, 1'b1, 1'b0);
    push("unmapped", 32'd0, 1'b1);
    smp();
    chk("unmapped_sels", {29'd0, sram_sel, uart_sel, sys_sel}, 32'd0);
    chk("unmapped_setup_pready", {31'd0, cpu.pready}, 32'd0);
    nxt();
    cpu.penable = 1'b1;
    nxt();
    bus(32'h0, 1'b0, 1'b0);

    // SYSTEM slave never ready: forced error on the 8th access cycle.
    nxt();
    bus(32'h0000_0100, 1'b1, 1'b0);
    sys_rdata = 32'hCAFE_0000; sys_ready = 1'b0;
    push("sys_timeout", 32'd0, 1'b1);
    smp();
    chk("sys_setup_sel", {29'd0, sram_sel, uart_sel, sys_sel}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      nxt();
      cpu.penable = 1'b1;
      smp();
      chk($sformatf("sys_enable_%0d", i), {31'd0, sys_enable}, 32'd1);
      if (i < 7) chk($sformatf("sys_wait_%0d", i), {31'd0, cpu.pready}, 32'd0);
    end
    nxt();
    bus(32'h0, 1'b0, 1'b0);

    // Access phase with no setup cycle is a protocol violation.
    nxt();
    bus(32'h8000_0000, 1'b1, 1'b1);
    sram_rdata = 32'h5555_5555; sram_ready = 1'b1;
    push("violation", 32'd0, 1'b1);
    smp();
    chk("violation_sram_enable", {31'd0, sram_enable}, 32'd0);
    nxt();
    bus(32'h0, 1'b0, 1'b0);
    sram_ready = 1'b0;

    // Back-to-back SRAM reads.
    nxt();
    bus(32'h8000_0004, 1'b1, 1'b0);
    sram_rdata = 32'h1111_1111; sram_ready = 1'b1;
    push("b2b_first", 32'h1111_1111, 1'b0);
    nxt();
    cpu.penable = 1'b1;
    nxt();
    bus(32'h8000_0008, 1'b1, 1'b0);
    sram_rdata = 32'h2222_2222;
    push("b2b_second", 32'h2222_2222, 1'b0);
    smp();
    chk("b2b_setup_enable", {31'd0, sram_enable}, 32'd0);
    nxt();
    cpu.penable = 1'b1;
    nxt();
    bus(32'h0, 1'b0, 1'b0);
    sram_ready = 1'b0;

    // Reset mid-access aborts with no completion.
    nxt();
    bus(32'h8000_0000, 1'b1, 1'b0);
    sram_rdata = 32'h7777_7777; sram_ready = 1'b0;
    nxt();
    cpu.penable = 1'b1;
    smp();
    chk("abort_wait_pready", {31'd0, cpu.pready}, 32'd0);
    nxt();
    #2;
    rts = 1'b0;
    #1;
    chk_all_zero("abort");
    sram_ready = 1'b1;
    #1;
    chk_all_zero("abort_ready");
    bus(32'h0, 1'b0, 1'b0);
    sram_ready = 1'b0;
    nxt();
    nxt();
    rts = 1'b1;

    // Normal read after reset release.
    nxt();
    bus(32'h8000_0000, 1'b1, 1'b0);
    sram_rdata = 32'h0BAD_F00D; sram_ready = 1'b1;
    push("post_reset", 32'h0BAD_F00D, 1'b0);
    nxt();
    cpu.penable = 1'b1;
    smp();
    chk("post_reset_enable", {31'd0, sram_enable}, 32'd1);
    nxt();
    bus(32'h0, 1'b0, 1'b0);
    sram_ready = 1'b0;
    nxt();
    smp();
    chk("pending_completions", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
